// File: rtl/rsa_operand_loader.sv
// Word-serial operand loader: assembles a WIDTH-bit RSA operand from WORD-bit
// valid/ready transfers (least significant word first) and strobes out_en once complete.
module rsa_operand_loader #(
  parameter int WIDTH  = 4096,
  parameter int WORD   = 32,
  // Derived; leave at their defaults.
  parameter int NWORDS = WIDTH / WORD,
  parameter int CW     = $clog2(NWORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WORD-1:0]  in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_en,
  output logic             busy,
  output logic [CW-1:0]    word_cnt,
  output logic             err_start
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t state;

  // The strobe is the COMMIT state itself, gated by clear so that an abort
  // landing on the commit cycle never reaches the downstream register enable.
  assign out_en = (state == COMMIT) && !clear;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_data  <= '0;
      word_cnt  <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      err_start <= 1'b0;
    end else begin
      err_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear) begin
            word_cnt <= '0;
          end else if (start) begin
            state    <= LOAD;
            word_cnt <= '0;
            out_data <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          if (clear) begin
            // Abort: any word presented this cycle is dropped.
            state    <= IDLE;
            word_cnt <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else begin
            err_start <= start;
            if (in_valid && in_ready) begin
              for (int k = 0; k < NWORDS; k++) begin
                if (word_cnt == CW'(k)) out_data[k*WORD +: WORD] <= in_data;
              end
              word_cnt <= word_cnt + CW'(1);
              if (word_cnt == CW'(NWORDS - 1)) begin
                state    <= COMMIT;
                in_ready <= 1'b0;
              end
            end
          end
        end

        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (clear) word_cnt <= '0;
          else       err_start <= start;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomized and directed bench for rsa_operand_loader (WIDTH=128, WORD=32),
// checked every cycle against a transaction-level model of the loader.
module tb_rsa_operand_loader;
  localparam int WIDTH  = 128;
  localparam int WORD   = 32;
  localparam int NWORDS = 4;
  localparam int CW     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [WORD-1:0]  in_data = '0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_en;
  logic             busy;
  logic [CW-1:0]    word_cnt;
  logic             err_start;

  rsa_operand_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data), .out_en(out_en), .busy(busy),
    .word_cnt(word_cnt), .err_start(err_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "loading" collects words into an array-like operand, "committing"
  // is the single strobe cycle after the last word.
  bit               m_loading = 0;
  bit               m_committing = 0;
  bit               m_err = 0;
  int               m_cnt = 0;
  logic [WIDTH-1:0] m_op = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 0; m_committing = 0; m_err = 0; m_cnt = 0; m_op = '0;
    end else begin
      m_err = 0;
      if (clear) begin
        m_loading = 0; m_committing = 0; m_cnt = 0;
      end else if (m_committing) begin
        m_committing = 0;
        m_err = start;
      end else if (m_loading) begin
        m_err = start;
        if (in_valid) begin
          m_op[m_cnt*WORD +: WORD] = in_data;
          m_cnt++;
          if (m_cnt == NWORDS) begin
            m_loading = 0;
            m_committing = 1;
          end
        end
      end else if (start) begin
        m_loading = 1; m_cnt = 0; m_op = '0;
      end
    end
  end

  int               n_en = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] cap = '0;

  always @(negedge clk) begin
    check("in_ready",  WIDTH'(in_ready),  WIDTH'(m_loading));
    check("busy",      WIDTH'(busy),      WIDTH'(m_loading || m_committing));
    check("word_cnt",  WIDTH'(word_cnt),  WIDTH'(m_cnt));
    check("out_data",  out_data,          m_op);
    check("out_en",    WIDTH'(out_en),    WIDTH'(m_committing && !clear));
    check("err_start", WIDTH'(err_start), WIDTH'(m_err));
    if (out_en) begin
      n_en++;
      cap = out_data;
    end
    if (err_start) n_err++;
  end

  // NOTE: inputs change 1 time unit after the rising edge with blocking
  // assignments, so DUT and model both see stable values at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [WORD-1:0] w, input int gap);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 20 && !acc; n++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake: in_ready low for 20 cycles, word %h", w);
    end
    repeat (gap) tick();
  endtask

  task automatic load4(input logic [WORD-1:0] a, b, c, d, input int gap);
    pulse_start();
    send(a, gap); send(b, gap); send(c, gap); send(d, gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, err0;

    #1;
    check("rst_out_data", out_data, '0);
    check("rst_busy", WIDTH'(busy), '0);
    check("rst_in_ready", WIDTH'(in_ready), '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Basic back-to-back load
    en0 = n_en;
    load4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0);
    check("basic_strobe", WIDTH'(out_en), WIDTH'(1));
    tick();
    check("basic_en_cnt", WIDTH'(n_en - en0), WIDTH'(1));
    check("basic_op", cap, 128'h44444444_33333333_22222222_11111111);
    check("basic_word_cnt", WIDTH'(word_cnt), WIDTH'(4));
    check("basic_busy", WIDTH'(busy), '0);

    // Gapped valid
    en0 = n_en;
    load4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 3);
    check("gap_en_cnt", WIDTH'(n_en - en0), WIDTH'(1));
    check("gap_op", cap, 128'h44444444_33333333_22222222_11111111);

    // Start during LOAD
    en0 = n_en; err0 = n_err;
    pulse_start();
    send(32'h55555555, 0); send(32'h66666666, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("dup_err_cnt", WIDTH'(n_err - err0), WIDTH'(1));
    check("dup_word_cnt", WIDTH'(word_cnt), WIDTH'(2));
    send(32'h77777777, 0); send(32'h88888888, 0);
    tick();
    check("dup_en_cnt", WIDTH'(n_en - en0), WIDTH'(1));
    check("dup_op", cap, 128'h88888888_77777777_66666666_55555555);

    // Abort after three words, then a clean reload
    en0 = n_en;
    pulse_start();
    send(32'h12345678, 0); send(32'h9abcdef0, 0); send(32'h0f0f0f0f, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("abort_en_cnt", WIDTH'(n_en - en0), '0);
    check("abort_word_cnt", WIDTH'(word_cnt), '0);
    check("abort_busy", WIDTH'(busy), '0);
    load4(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 1);
    check("reload_en_cnt", WIDTH'(n_en - en0), WIDTH'(1));
    check("reload_op", cap, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);

    // Clear together with start on the COMMIT cycle, then a collision in IDLE
    en0 = n_en; err0 = n_err;
    load4(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 0);
    clear = 1'b1;
    start = 1'b1;
    #1;
    check("commit_clr_out_en", WIDTH'(out_en), '0);
    tick();
    clear = 1'b0;
    start = 1'b0;
    tick();
    check("commit_clr_en_cnt", WIDTH'(n_en - en0), '0);
    check("commit_clr_busy", WIDTH'(busy), '0);
    check("commit_clr_word_cnt", WIDTH'(word_cnt), '0);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    tick();
    check("collide_err_cnt", WIDTH'(n_err - err0), '0);
    check("collide_busy", WIDTH'(busy), '0);
    check("collide_in_ready", WIDTH'(in_ready), '0);

    // Asynchronous reset mid-load
    en0 = n_en;
    pulse_start();
    send(32'hdeadbeef, 0); send(32'hcafef00d, 0);
    #3 rst = 1'b1;
    #1;
    check("arst_out_data", out_data, '0);
    check("arst_word_cnt", WIDTH'(word_cnt), '0);
    check("arst_busy", WIDTH'(busy), '0);
    check("arst_in_ready", WIDTH'(in_ready), '0);
    check("arst_out_en", WIDTH'(out_en), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("arst_en_cnt", WIDTH'(n_en - en0), '0);
    load4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0);
    tick();
    check("arst_reload_en_cnt", WIDTH'(n_en - en0), WIDTH'(1));
    check("arst_reload_op", cap, 128'h44444444_33333333_22222222_11111111);

    // Random traffic: sporadic start/clear, random valid and data
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      clear    = ($urandom_range(0, 31) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = $urandom;
      tick();
    end
    start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
